// File: rtl/inv_sub_layer_iter.sv
// ---------------------------------------------------------------------------
// inv_sub_layer_iter
//
// Iterative inverse of the Ascon substitution layer. A 5 x NUM_COLUMNS state
// is captured, then NUM_SBOXES_PER_CYCLE bit-columns per clock are replaced
// by their inverse S-box images. The finished state is held until the
// consumer takes it.
//
// Column i is {s0[i], s1[i], s2[i], s3[i], s4[i]}, with word 0 as the MSB.
//
// Ports
//   clock    in   rising-edge system clock
//   reset    in   asynchronous active-high reset
//   i_valid  in   i_state is valid (sampled only in IDLE)
//   o_ready  out  block can accept a state (IDLE)
//   i_state  in   5 x NUM_COLUMNS state to invert
//   o_valid  out  o_state holds a completed result (DONE)
//   i_ready  in   downstream accepts the result
//   o_state  out  inverse-substituted state (working register)
//   o_busy   out  high while columns are being processed (BUSY)
// ---------------------------------------------------------------------------
module inv_sub_layer_iter #(
  parameter int NUM_COLUMNS          = 64,
  parameter int NUM_SBOXES_PER_CYCLE = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [4:0][NUM_COLUMNS-1:0]   i_state,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [4:0][NUM_COLUMNS-1:0]   o_state,
  output logic                          o_busy
);

  localparam int NUM_CHUNKS = NUM_COLUMNS / NUM_SBOXES_PER_CYCLE;
  // One counter bit is kept even when the whole state fits in one chunk.
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int COL_W      = $clog2(NUM_COLUMNS);
  localparam int SH         = $clog2(NUM_SBOXES_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                         state_r;
  logic [CNT_W-1:0]               cnt_r;
  logic [4:0][NUM_COLUMNS-1:0]    work_r;
  logic [4:0][NUM_COLUMNS-1:0]    work_next_s;
  logic                           ready_r;
  logic                           valid_r;
  logic                           busy_r;
  logic [COL_W-1:0]               base_s;
  logic [COL_W-1:0]               col_idx_s;
  logic [4:0]                     col_in_s;
  logic [4:0]                     col_out_s;

  // Inverse Ascon S-box: returns x such that S(x) = y.
  function automatic logic [4:0] inv_sbox(input logic [4:0] y);
    logic [4:0] x;
    case (y)
      5'h00: x = 5'h14;  5'h01: x = 5'h1a;  5'h02: x = 5'h07;  5'h03: x = 5'h0d;
      5'h04: x = 5'h00;  5'h05: x = 5'h09;  5'h06: x = 5'h0e;  5'h07: x = 5'h12;
      5'h08: x = 5'h0a;  5'h09: x = 5'h06;  5'h0a: x = 5'h1d;  5'h0b: x = 5'h01;
      5'h0c: x = 5'h19;  5'h0d: x = 5'h15;  5'h0e: x = 5'h13;  5'h0f: x = 5'h1e;
      5'h10: x = 5'h18;  5'h11: x = 5'h16;  5'h12: x = 5'h0b;  5'h13: x = 5'h11;
      5'h14: x = 5'h03;  5'h15: x = 5'h05;  5'h16: x = 5'h1c;  5'h17: x = 5'h1f;
      5'h18: x = 5'h17;  5'h19: x = 5'h1b;  5'h1a: x = 5'h04;  5'h1b: x = 5'h08;
      5'h1c: x = 5'h0f;  5'h1d: x = 5'h0c;  5'h1e: x = 5'h10;  5'h1f: x = 5'h02;
      default: x = 5'h00;
    endcase
    return x;
  endfunction

  // Working register with the current chunk of columns inverse-substituted.
  always_comb begin
    work_next_s = work_r;
    // Chunks are power-of-two sized, so the chunk base is a plain shift.
    base_s      = COL_W'(cnt_r) << SH;
    col_idx_s   = '0;
    col_in_s    = 5'd0;
    col_out_s   = 5'd0;
    for (int j = 0; j < NUM_SBOXES_PER_CYCLE; j++) begin
      col_idx_s = base_s | COL_W'(j);
      col_in_s  = {work_r[0][col_idx_s], work_r[1][col_idx_s], work_r[2][col_idx_s],
                   work_r[3][col_idx_s], work_r[4][col_idx_s]};
      col_out_s = inv_sbox(col_in_s);
      for (int w = 0; w < 5; w++) begin
        work_next_s[w][col_idx_s] = col_out_s[4-w];
      end
    end
  end

  // Control FSM, chunk counter, working register and registered flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      work_r  <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            work_r  <= i_state;
            cnt_r   <= '0;
            state_r <= ST_BUSY;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_BUSY: begin
          work_r <= work_next_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= '0;
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_busy  = busy_r;
  assign o_state = work_r;

endmodule

// File: tb/tb_inv_sub_layer_iter.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_layer_iter
//
// Directed-vector bench for inv_sub_layer_iter. Three instances (8, 1 and 64
// S-boxes per cycle) share the same stimulus; the 8-wide one is the main
// target, the other two are used for the latency corner cases.
// ---------------------------------------------------------------------------
module tb_inv_sub_layer_iter;

  typedef logic [4:0][63:0] st_t;

  typedef struct {
    string name;
    st_t   st;
    st_t   exp;
  } vec_t;

  logic clock;
  logic reset;
  logic i_valid;
  logic i_ready;
  st_t  i_state;

  logic o_ready8,  o_valid8,  o_busy8;
  logic o_ready1,  o_valid1,  o_busy1;
  logic o_ready64, o_valid64, o_busy64;
  st_t  o_state8, o_state1, o_state64;

  int n_vec;
  int n_fail;

  // Forward Ascon S-box, x = 0..31.
  logic [4:0] fwd [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                           5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                           5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                           5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  inv_sub_layer_iter #(.NUM_COLUMNS(64), .NUM_SBOXES_PER_CYCLE(8)) dut8 (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready8),
    .i_state(i_state), .o_valid(o_valid8), .i_ready(i_ready),
    .o_state(o_state8), .o_busy(o_busy8));

  inv_sub_layer_iter #(.NUM_COLUMNS(64), .NUM_SBOXES_PER_CYCLE(1)) dut1 (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready1),
    .i_state(i_state), .o_valid(o_valid1), .i_ready(i_ready),
    .o_state(o_state1), .o_busy(o_busy1));

  inv_sub_layer_iter #(.NUM_COLUMNS(64), .NUM_SBOXES_PER_CYCLE(64)) dut64 (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready64),
    .i_state(i_state), .o_valid(o_valid64), .i_ready(i_ready),
    .o_state(o_state64), .o_busy(o_busy64));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Forward layer: the reference substitution applied column by column.
  function automatic st_t fwd_layer(input st_t s);
    st_t        r;
    logic [4:0] c;
    logic [4:0] y;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      c = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
      y = fwd[c];
      for (int w = 0; w < 5; w++) r[w][i] = y[4-w];
    end
    return r;
  endfunction

  // State whose column i holds the 5-bit value v(i).
  function automatic st_t cols_of(input int mode);
    st_t        r;
    logic [4:0] v;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      v = (mode == 0) ? 5'(i % 32) : fwd[i % 32];
      for (int w = 0; w < 5; w++) r[w][i] = v[4-w];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept one state on dut8, check latency, busy length, result, return to IDLE.
  task automatic run_one(input string name, input st_t st, input st_t exp);
    int cyc;
    int busy;
    @(negedge clock);
    chk({name, " ready"}, 320'(o_ready8), 320'(1'b1));
    i_state = st;
    i_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_valid = 1'b0;
    cyc  = 0;
    busy = 0;
    while (!o_valid8 && cyc < 20) begin
      if (o_busy8) busy++;
      @(negedge clock);
      cyc++;
    end
    chk({name, " latency"}, 320'(cyc), 320'(8));
    chk({name, " busy"}, 320'(busy), 320'(8));
    chk({name, " state"}, o_state8, exp);
    @(negedge clock);
    chk({name, " idle"}, 320'({o_ready8, o_valid8}), 320'(2'b10));
  endtask

  vec_t vecs[5];
  st_t  ones;
  st_t  sa;
  st_t  ea;
  st_t  x;
  int   lat1, lat8, lat64;
  st_t  got1, got8, got64;

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_state = '0;
    ones    = '1;

    vecs[0].name = "zero";
    vecs[0].st   = '0;
    vecs[0].exp  = '0;
    vecs[0].exp[0] = ones[0];
    vecs[0].exp[2] = ones[0];
    vecs[1].name = "word2";
    vecs[1].st   = '0;
    vecs[1].st[2] = ones[0];
    vecs[1].exp  = '0;
    vecs[2].name = "sbox_cols";
    vecs[2].st   = cols_of(1);
    vecs[2].exp  = cols_of(0);
    vecs[3].name = "all_ones";
    vecs[3].st   = '1;
    vecs[3].exp  = '0;
    vecs[3].exp[3] = ones[0];
    vecs[4].name = "word0";
    vecs[4].st   = '0;
    vecs[4].st[0] = ones[0];
    vecs[4].exp  = '0;
    vecs[4].exp[0] = ones[0];
    vecs[4].exp[1] = ones[0];

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst o_valid", 320'(o_valid8), 320'(1'b0));
    chk("rst o_busy", 320'(o_busy8), 320'(1'b0));
    chk("rst o_state", o_state8, 320'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("rst o_ready", 320'(o_ready8), 320'(1'b1));

    for (int k = 0; k < 5; k++) run_one(vecs[k].name, vecs[k].st, vecs[k].exp);

    // Hold in DONE with i_ready low while i_valid pulses and i_state changes.
    sa = cols_of(1);
    ea = cols_of(0);
    @(negedge clock);
    i_ready = 1'b0;
    i_state = sa;
    i_valid = 1'b1;
    @(negedge clock);
    i_valid = 1'b0;
    for (int c = 0; c < 20 && !o_valid8; c++) @(negedge clock);
    chk("hold reach", 320'(o_valid8), 320'(1'b1));
    for (int c = 0; c < 5; c++) begin
      i_valid = c[0];
      i_state = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clock);
      chk("hold valid", 320'(o_valid8), 320'(1'b1));
      chk("hold ready", 320'(o_ready8), 320'(1'b0));
      chk("hold state", o_state8, ea);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clock);
    chk("release", 320'({o_ready8, o_valid8}), 320'(2'b10));

    // Reset during BUSY cycle 3 clears outputs without a clock edge.
    @(negedge clock);
    i_state = '1;
    i_valid = 1'b1;
    @(negedge clock);
    i_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre-abort busy", 320'(o_busy8), 320'(1'b1));
    #2 reset = 1'b1;
    #1;
    chk("abort outs", 320'({o_valid8, o_busy8, o_ready8}), 320'(3'b001));
    chk("abort state", o_state8, 320'(0));
    #1 reset = 1'b0;
    run_one("after_abort", vecs[0].st, vecs[0].exp);

    // Latency per instance width: 64-wide -> 1, 8-wide -> 8, 1-wide -> 64.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    i_state = sa;
    i_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_valid = 1'b0;
    lat1 = -1; lat8 = -1; lat64 = -1;
    got1 = '0; got8 = '0; got64 = '0;
    for (int c = 0; c < 70; c++) begin
      if (o_valid1  && lat1  < 0) begin lat1  = c; got1  = o_state1;  end
      if (o_valid8  && lat8  < 0) begin lat8  = c; got8  = o_state8;  end
      if (o_valid64 && lat64 < 0) begin lat64 = c; got64 = o_state64; end
      @(negedge clock);
    end
    chk("lat N64", 320'(lat64), 320'(1));
    chk("lat N8", 320'(lat8), 320'(8));
    chk("lat N1", 320'(lat1), 320'(64));
    chk("state N64", got64, ea);
    chk("state N8", got8, ea);
    chk("state N1", got1, ea);

    // Random round trips through the forward layer.
    for (int r = 0; r < 1000; r++) begin
      x = {$urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom};
      run_one("roundtrip", fwd_layer(x), x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_sub_layer_iter.md
Name: inv_sub_layer_iter

Overview:
- Iterative inverse of the Ascon substitution layer. Applies the inverse 5-bit Ascon S-box to all 64 bit-columns of a 5x64 state, processing a fixed number of columns per clock cycle.
- Sits in the decryption/permutation-inverse datapath, paired with the forward substitution layer.
- Uses a valid/ready handshake on both sides and holds its result until consumed.

Parameters:
- NUM_COLUMNS, 64, number of bit-columns in the state (word width); fixed by t_state_array.
- NUM_SBOXES_PER_CYCLE, 8, inverse S-boxes instantiated; must divide NUM_COLUMNS (legal: 1,2,4,8,16,32,64).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  input state valid.
- o_ready  output  1  block can accept a state.
- i_state  input  t_state_array (5x64)  state to invert; word 0 is column MSB.
- o_valid  output  1  o_state holds a completed result.
- i_ready  input  1  downstream accepts result.
- o_state  output  t_state_array (5x64)  inverse-substituted state.
- o_busy  output  1  high while columns are being processed.

Behaviour:
- Column i is the 5-bit value {s0[i],s1[i],s2[i],s3[i],s4[i]} (s0 = MSB). The output column is InvS(column), with InvS the exact inverse of the Ascon S-box.
  - Forward table, x=0..31: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
  - InvS(y)=x where S(x)=y, e.g. InvS(00)=14, InvS(04)=00, InvS(1f)=02.
  - The inverse S-box is pure combinational logic inside this block.
- Reset (async, active-high), all outputs:
  - FSM=IDLE, column counter=0, working register=0.
  - o_state=0, o_valid=0, o_busy=0, o_ready=1 (after reset deasserts).
- FSM states:
  - IDLE: o_ready=1. On a rising edge with i_valid=1, capture i_state into the working register, clear the counter, go to BUSY.
  - BUSY: o_ready=0, o_busy=1. Each edge replaces columns [c*N .. c*N+N-1] of the working register with their InvS images, where N=NUM_SBOXES_PER_CYCLE and c=counter, then increments the counter. When the counter reaches NUM_COLUMNS/N-1, that edge writes the final chunk, wraps the counter to 0 and goes to DONE.
  - DONE: o_valid=1, o_state=working register, held stable while i_ready=0. On an edge with i_ready=1, go to IDLE and drop o_valid.
- Latency:
  - Acceptance edge E; o_valid=1 after edge E+NUM_COLUMNS/N (default E+8).
  - Minimum acceptance-to-acceptance interval is NUM_COLUMNS/N+2 cycles with i_ready tied high.
- o_ready is a function of state only; no combinational path from i_valid or i_ready to any output.
- i_valid outside IDLE is ignored and i_state is not sampled; i_state changes during BUSY do not affect the result.
- o_state may show partially processed data only while o_valid=0; consumers sample it solely under o_valid.
- Parameter N=64: BUSY lasts exactly one cycle. N=1: BUSY lasts 64 cycles.
- Reset asserted in any state aborts the operation immediately (asynchronously); the partial result is discarded and the block returns to IDLE.
- Composition identity: sub_layer followed by inv_sub_layer_iter returns the original state for every input.

Test Plan:
- All-zero i_state, i_ready=1 → o_valid exactly 8 cycles after acceptance; o_state words 0 and 2 = 0xFFFFFFFFFFFFFFFF, words 1,3,4 = 0.
- Word 2 = all ones, others 0 → o_state all zero; o_busy high for exactly 8 cycles.
- Column i loaded with forward S(i mod 32) for i=0..63 → column i of o_state equals i mod 32; repeat with NUM_SBOXES_PER_CYCLE=1 (64-cycle latency) and 64 (1-cycle latency).
- i_ready held low 5 cycles in DONE, while i_valid pulses and i_state changes → o_state/o_valid stable, o_ready=0, no new capture; after i_ready=1, o_ready=1 next cycle.
- Reset asserted at BUSY cycle 3 → o_valid, o_busy, o_state go to 0 without a clock edge; next accepted state produces the correct full result.
- 1000 random states fed through sub_layer then this block → output equals original state each time.
